// File: rtl/instr_trace_buffer.sv
// Retire-trace capture unit: detects instruction retirement by PC change on the
// core probes and records {pc, instr, cycles} into a DEPTH-entry readout buffer.
module instr_trace_buffer #(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int STATE_W = 7,
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [XLEN-1:0]            PCData,
    input  logic [ILEN-1:0]            i31_0,
    input  logic [STATE_W-1:0]         state_out,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       stop_on_full,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [ILEN-1:0]            rd_instr,
    output logic [CYC_W-1:0]           rd_cycles,
    output logic [STATE_W-1:0]         last_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [XLEN-1:0]    pc_q_r;
    logic [ILEN-1:0]    ir_q_r;
    logic [STATE_W-1:0] last_state_r;
    logic [CYC_W-1:0]   cyc_cnt_r;
    logic [CYC_W-1:0]   cyc_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               overflow_r;
    logic               busy_r;
    logic               done_r;
    logic               rd_valid_r;

    logic               flush_s;
    logic               retire_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               overwrite_s;
    logic               fill_stop_s;
    logic               trig_hit_s;

    logic [XLEN-1:0]    pc_mem_r    [DEPTH];
    logic [ILEN-1:0]    instr_mem_r [DEPTH];
    logic [CYC_W-1:0]   cyc_mem_r   [DEPTH];

    // Retire detection, buffer push/pop decisions and next-state selection
    always_comb begin
        flush_s     = clear || arm;
        retire_s    = (state_r == ST_CAPTURE) && (PCData != pc_q_r);
        full_s      = (count_r == CNT_FULL);
        pop_s       = rd_ready && (count_r != CNT_ZERO) && !flush_s;
        // A full stop-on-full buffer drops the retire unless a pop frees a slot.
        push_s      = retire_s && !flush_s && (!full_s || pop_s || !stop_on_full);
        overwrite_s = push_s && full_s && !pop_s;
        fill_stop_s = push_s && !pop_s && stop_on_full && (count_r == (CNT_FULL - CNT_ONE));
        trig_hit_s  = !trig_en || (PCData == trig_pc);

        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else if (arm) begin
            state_nxt_s = ST_ARMED;
        end else if (stop && ((state_r == ST_ARMED) || (state_r == ST_CAPTURE))) begin
            state_nxt_s = ST_DONE;
        end else begin
            case (state_r)
                ST_ARMED:   state_nxt_s = trig_hit_s ? ST_CAPTURE : ST_ARMED;
                ST_CAPTURE: state_nxt_s = fill_stop_s ? ST_DONE : ST_CAPTURE;
                default:    state_nxt_s = state_r;
            endcase
        end
    end

    // Occupancy and per-instruction cycle counter updates
    always_comb begin
        count_nxt_s = count_r;
        if (flush_s) begin
            count_nxt_s = CNT_ZERO;
        end else if (push_s && !pop_s && !full_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end

        cyc_nxt_s = cyc_cnt_r;
        if ((state_r == ST_ARMED) && (state_nxt_s == ST_CAPTURE)) begin
            cyc_nxt_s = CYC_ONE;
        end else if (state_r == ST_CAPTURE) begin
            if (retire_s) begin
                cyc_nxt_s = CYC_ONE;
            end else if (cyc_cnt_r != CYC_MAX) begin
                cyc_nxt_s = cyc_cnt_r + CYC_ONE;
            end else begin
                cyc_nxt_s = cyc_cnt_r;
            end
        end else begin
            cyc_nxt_s = cyc_cnt_r;
        end
    end

    // Control state, probe pipeline, pointers and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            pc_q_r       <= {XLEN{1'b0}};
            ir_q_r       <= {ILEN{1'b0}};
            last_state_r <= {STATE_W{1'b0}};
            cyc_cnt_r    <= {CYC_W{1'b0}};
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_q_r       <= PCData;
            ir_q_r       <= i31_0;
            last_state_r <= state_out;
            cyc_cnt_r    <= cyc_nxt_s;
            count_r      <= count_nxt_s;
            busy_r       <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_CAPTURE);
            done_r       <= (state_nxt_s == ST_DONE);
            rd_valid_r   <= (count_nxt_s != CNT_ZERO);
            if (flush_s) begin
                wr_ptr_r   <= PTR_ZERO;
                rd_ptr_r   <= PTR_ZERO;
                overflow_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                // Overwriting the oldest entry retires it from the head as well.
                if (pop_s || overwrite_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (overwrite_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // Entry storage; contents need no reset because rd_valid qualifies them
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= pc_q_r;
            instr_mem_r[wr_ptr_r] <= ir_q_r;
            cyc_mem_r[wr_ptr_r]   <= cyc_cnt_r;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign count      = count_r;
    assign rd_valid   = rd_valid_r;
    assign rd_pc      = pc_mem_r[rd_ptr_r];
    assign rd_instr   = instr_mem_r[rd_ptr_r];
    assign rd_cycles  = cyc_mem_r[rd_ptr_r];
    assign last_state = last_state_r;

endmodule
